// File: rtl/mod_prog_pkg.sv
// Shared encodings for the programmable modulo counter.
package mod_prog_pkg;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage : mod_prog_pkg

// File: rtl/mod_prog_shadow.sv
// Double-buffered modulus: shadow register, active register, pending flag.
// o_m is the modulus in force now, o_m_nxt the one in force after this cycle.
module mod_prog_shadow #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned RST_MOD = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_mod_wr,
    input  logic [WIDTH-1:0] i_mod_val,
    input  logic             i_xfer,
    output logic [WIDTH:0]   o_m,
    output logic [WIDTH:0]   o_m_nxt,
    output logic             o_mod_pend
);

    logic [WIDTH-1:0] r_mod_act;
    logic [WIDTH-1:0] r_mod_shd;
    logic             r_mod_pend;
    logic [WIDTH-1:0] w_act_nxt;

    // A write landing on a transfer cycle bypasses the shadow.
    assign w_act_nxt = i_xfer ? (i_mod_wr ? i_mod_val : r_mod_shd) : r_mod_act;

    // Zero encodes the full 2^WIDTH range.
    assign o_m     = (r_mod_act == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, r_mod_act};
    assign o_m_nxt = (w_act_nxt == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, w_act_nxt};

    assign o_mod_pend = r_mod_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mod_act  <= WIDTH'(RST_MOD);
            r_mod_shd  <= WIDTH'(RST_MOD);
            r_mod_pend <= 1'b0;
        end else begin
            r_mod_act <= w_act_nxt;
            if (i_mod_wr) begin
                r_mod_shd <= i_mod_val;
            end
            if (i_xfer) begin
                r_mod_pend <= 1'b0;
            end else if (i_mod_wr) begin
                r_mod_pend <= 1'b1;
            end
        end
    end

endmodule : mod_prog_shadow

// File: rtl/mod_prog.sv
// Runtime-programmable modulo counter: up/down, free-run or one-shot,
// parallel load, double-buffered modulus, chainable terminal-count strobe.
module mod_prog
    import mod_prog_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned RST_MOD = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             dir,
    input  logic             oneshot,
    input  logic             start,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] q,
    output logic             sync_tc,
    output logic             running,
    output logic             done,
    output logic             mod_pend
);

    localparam int unsigned MW = WIDTH + 1;

    logic [WIDTH-1:0] r_q;
    logic             r_running;
    logic             r_done;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_running_nxt;
    logic             w_done_nxt;

    logic [WIDTH:0]   w_m;
    logic [WIDTH:0]   w_m_nxt;
    logic [WIDTH-1:0] w_top_nxt;
    logic             w_oneshot;
    logic             w_down;
    logic             w_step;
    logic             w_at_term;
    logic             w_xfer;

    mod_prog_shadow #(
        .WIDTH   (WIDTH),
        .RST_MOD (RST_MOD)
    ) u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_mod_wr   (mod_wr),
        .i_mod_val  (mod_val),
        .i_xfer     (w_xfer),
        .o_m        (w_m),
        .o_m_nxt    (w_m_nxt),
        .o_mod_pend (mod_pend)
    );

    assign w_oneshot = (oneshot == MODE_ONESHOT);
    assign w_down    = (dir == DIR_DOWN);
    assign w_top_nxt = WIDTH'(w_m_nxt - MW'(1));

    // Terminal detect uses the modulus in force during this cycle.
    assign w_step    = cen & (w_oneshot ? r_running : 1'b1);
    assign w_at_term = w_down ? (r_q == '0) : ({1'b0, r_q} == (w_m - MW'(1)));
    assign sync_tc   = w_step & w_at_term & ~clr & ~load;
    assign w_xfer    = clr | load | sync_tc;

    // Next-state: clr > load > step; wrap/reload values use the post-transfer modulus.
    always_comb begin
        w_q_nxt       = r_q;
        w_running_nxt = r_running;
        w_done_nxt    = r_done;
        if (clr) begin
            w_q_nxt       = w_down ? w_top_nxt : '0;
            w_running_nxt = 1'b0;
            w_done_nxt    = 1'b0;
        end else if (load) begin
            w_q_nxt = ({1'b0, load_val} >= w_m_nxt) ? w_top_nxt : load_val;
        end else begin
            if (w_step) begin
                if (w_down) begin
                    w_q_nxt = (r_q == '0) ? w_top_nxt : r_q - WIDTH'(1);
                end else begin
                    w_q_nxt = sync_tc ? '0 : r_q + WIDTH'(1);
                end
            end
            if (w_oneshot && sync_tc) begin
                w_running_nxt = 1'b0;
                w_done_nxt    = 1'b1;
            end
            // A restart on the completion cycle keeps that completion's done.
            if (w_oneshot && start) begin
                w_running_nxt = 1'b1;
                w_done_nxt    = sync_tc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_q       <= w_q_nxt;
            r_running <= w_running_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign q       = r_q;
    assign running = w_oneshot ? r_running : 1'b1;
    assign done    = r_done;

endmodule : mod_prog

// File: tb/tb_mod_prog.sv
// Directed and randomized bench for mod_prog against an arithmetic reference model.
module tb_mod_prog;

    localparam int unsigned W    = 16;
    localparam int          FULL = 1 << W;
    localparam int          RSTM = 256;

    logic         clk = 1'b0;
    logic         rst_n, cen, dir, oneshot, start, clr, load, mod_wr;
    logic [W-1:0] load_val, mod_val;
    logic [W-1:0] q;
    logic         sync_tc, running, done, mod_pend;

    int checks = 0;
    int errors = 0;

    // Reference state: active/shadow modulus, pending flag, count and one-shot flags.
    int m_q, m_act, m_shd, m_pend, m_run, m_done;

    mod_prog #(.WIDTH(W), .RST_MOD(RSTM)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .dir      (dir),
        .oneshot  (oneshot),
        .start    (start),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .mod_wr   (mod_wr),
        .mod_val  (mod_val),
        .q        (q),
        .sync_tc  (sync_tc),
        .running  (running),
        .done     (done),
        .mod_pend (mod_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dec(input int v);
        return (v == 0) ? FULL : v;
    endfunction

    task automatic model_reset();
        m_q = 0; m_act = RSTM; m_shd = RSTM; m_pend = 0; m_run = 0; m_done = 0;
    endtask

    task automatic idle();
        start = 1'b0; clr = 1'b0; load = 1'b0; mod_wr = 1'b0;
    endtask

    // One clock: predict from the rules, check the strobe before the edge and state after it.
    task automatic cyc();
        int  m, mn, nact, nq, nrun, ndone;
        bit  stp, tc, xf;
        m   = dec(m_act);
        stp = cen && (oneshot ? (m_run != 0) : 1'b1);
        tc  = stp && !clr && !load && (m_q == (dir ? 0 : m - 1));
        #1;
        chk("sync_tc", 32'(sync_tc), 32'(tc));
        xf   = clr || load || tc;
        nact = xf ? (mod_wr ? int'(mod_val) : m_shd) : m_act;
        mn   = dec(nact);
        nq = m_q; nrun = m_run; ndone = m_done;
        if (clr) begin
            nq = dir ? mn - 1 : 0; nrun = 0; ndone = 0;
        end else if (load) begin
            nq = (int'(load_val) < mn) ? int'(load_val) : mn - 1;
        end else begin
            if (stp) nq = dir ? ((m_q == 0) ? mn - 1 : m_q - 1) : (m_q + 1) % m;
            if (oneshot && tc) begin nrun = 0; ndone = 1; end
            if (oneshot && start) begin nrun = 1; if (!tc) ndone = 0; end
        end
        if (mod_wr) m_shd = int'(mod_val);
        m_pend = xf ? 0 : (mod_wr ? 1 : m_pend);
        m_act  = nact;
        @(posedge clk);
        m_q = nq; m_run = nrun; m_done = ndone;
        #1;
        chk("q", 32'(q), m_q);
        chk("mod_pend", 32'(mod_pend), m_pend);
        chk("done", 32'(done), m_done);
        chk("running", 32'(running), oneshot ? m_run : 1);
        @(negedge clk);
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Clear and program the modulus in one write-through cycle.
    task automatic setup(input int modv, input logic d, input logic os);
        idle(); cen = 1'b0; dir = d; oneshot = os;
        clr = 1'b1; mod_wr = 1'b1; mod_val = W'(modv);
        cyc();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0; cen = 1'b0; dir = 1'b0; oneshot = 1'b1;
        load_val = '0; mod_val = '0;
        model_reset();
        #12;
        chk("rst_q", 32'(q), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pend", 32'(mod_pend), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Up free-run, M=5
        setup(5, 1'b0, 1'b0);
        chk("up_pend_wt", 32'(mod_pend), 0);
        cen = 1'b1;
        cycn(12);
        chk("up_q_end", 32'(q), 2);

        // Down, M=4, direction switched after the clear
        setup(4, 1'b0, 1'b0);
        dir = 1'b1; cen = 1'b1;
        cycn(6);

        // Shadow write mid-count, then a write coincident with the wrap
        setup(6, 1'b0, 1'b0);
        cen = 1'b1;
        cycn(2);
        mod_wr = 1'b1; mod_val = W'(3);
        cyc();
        mod_wr = 1'b0;
        chk("pend_set", 32'(mod_pend), 1);
        cycn(3);
        chk("wrap_q", 32'(q), 0);
        cycn(2);
        mod_wr = 1'b1; mod_val = W'(7);
        cyc();
        mod_wr = 1'b0;
        chk("wt_pend", 32'(mod_pend), 0);
        cycn(8);

        // One-shot up, M=3
        setup(3, 1'b0, 1'b1);
        start = 1'b1;
        cyc();
        start = 1'b0; cen = 1'b1;
        cycn(6);
        chk("os_hold_q", 32'(q), 0);
        chk("os_done", 32'(done), 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cycn(2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("os_restart_run", 32'(running), 1);
        cycn(4);

        // Saturating load, then clr+load+cen together
        setup(6, 1'b0, 1'b1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        load = 1'b1; load_val = W'(9);
        cyc();
        load = 1'b0;
        chk("load_sat", 32'(q), 5);
        clr = 1'b1; load = 1'b1; load_val = W'(2); cen = 1'b1;
        cyc();
        idle();
        chk("clr_wins_q", 32'(q), 0);

        // Modulus 0 means full range; then asynchronous reset mid-count
        setup(0, 1'b0, 1'b0);
        load = 1'b1; load_val = W'(FULL - 1);
        cyc();
        load = 1'b0; cen = 1'b1;
        cycn(3);
        mod_wr = 1'b1; mod_val = W'(9);
        cyc();
        mod_wr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("amid_q", 32'(q), 0);
        chk("amid_pend", 32'(mod_pend), 0);
        chk("amid_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        load = 1'b1; load_val = W'(300);
        cyc();
        load = 1'b0;
        chk("rst_mod_sat", 32'(q), RSTM - 1);

        // Randomized traffic with small moduli
        setup(5, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            cen   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 31) == 0) oneshot = ~oneshot;
            start = ($urandom_range(0, 7) == 0);
            clr   = ($urandom_range(0, 39) == 0);
            load  = ($urandom_range(0, 19) == 0);
            load_val = W'($urandom_range(0, 15));
            mod_wr   = ($urandom_range(0, 9) == 0);
            mod_val  = W'($urandom_range(1, 9));
            cyc();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mod_prog
